// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM tile controller: FSM state encoding and
// the pipeline flush-length helper.
// Imported by gemm_tile_ctrl and available to any block that decodes its state.
package gemm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Cycles of zero-injection needed for the last operand wavefront to
    // traverse a skewed ROWS x COLS systolic array.
    function automatic int flush_len(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/gemm_tile_ctrl.sv
// Purpose: sequences one GEMM tile on an external systolic array: clear, feed K operands, flush, drain rows.
// Latency: K + ROWS + COLS + ROWS + 1 cycles from start accept to done when never stalled.
// Backpressure: operand_valid=0 freezes the array in FEED; drain_ready=0 holds the offered row in DRAIN.
//
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   start, k_len                    - tile request (accepted only in IDLE), reduction length
//   operand_valid, drain_ready      - upstream operand availability, downstream result acceptance
//   busy, done                      - tile in progress, one-cycle completion pulse
//   clear_acc, en, feed_k, feed_zero- PE array / skew buffer controls
//   drain_valid, drain_row          - result row offered to the sink
//   perf_cycles, perf_stalls        - only with GEMM_TILE_CTRL_PERF_EN defined
module gemm_tile_ctrl
    import gemm_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int K_W  = 16,
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [K_W-1:0]  k_len,
    input  logic            operand_valid,
    input  logic            drain_ready,
    output logic            busy,
    output logic            done,
    output logic            clear_acc,
    output logic            en,
    output logic [K_W-1:0]  feed_k,
    output logic            feed_zero,
    output logic            drain_valid,
`ifdef GEMM_TILE_CTRL_PERF_EN
    output logic [31:0]     perf_cycles,
    output logic [31:0]     perf_stalls,
`endif
    output logic [RW-1:0]   drain_row
);

    localparam int FLUSH_LEN = flush_len(ROWS, COLS);
    localparam int FL_W      = $clog2(FLUSH_LEN + 1);

    state_t           state_q, state_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [K_W-1:0]   feed_cnt_q, feed_cnt_d;
    logic [FL_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [RW-1:0]    drain_cnt_q, drain_cnt_d;
    logic             accept;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        feed_cnt_d  = feed_cnt_q;
        flush_cnt_d = flush_cnt_q;
        drain_cnt_d = drain_cnt_q;
        accept      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        clear_acc   = 1'b0;
        en          = 1'b0;
        feed_k      = '0;
        feed_zero   = 1'b0;
        drain_valid = 1'b0;
        drain_row   = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    k_d     = k_len;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                busy        = 1'b1;
                clear_acc   = 1'b1;
                feed_cnt_d  = '0;
                flush_cnt_d = '0;
                drain_cnt_d = '0;
                // A zero-length reduction has nothing to feed or flush.
                state_d     = (k_q != '0) ? ST_FEED : ST_DRAIN;
            end
            ST_FEED: begin
                busy   = 1'b1;
                en     = operand_valid;
                feed_k = feed_cnt_q;
                if (operand_valid) begin
                    // k_q is non-zero here, so K-1 cannot underflow; the
                    // counter never needs to reach K, so K_W bits suffice.
                    if (feed_cnt_q == k_q - K_W'(1)) begin
                        state_d = ST_FLUSH;
                    end else begin
                        feed_cnt_d = feed_cnt_q + K_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                busy      = 1'b1;
                en        = 1'b1;
                feed_zero = 1'b1;
                if (flush_cnt_q == FL_W'(FLUSH_LEN - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    flush_cnt_d = flush_cnt_q + FL_W'(1);
                end
            end
            ST_DRAIN: begin
                busy        = 1'b1;
                drain_valid = 1'b1;
                drain_row   = drain_cnt_q;
                if (drain_ready) begin
                    if (drain_cnt_q == RW'(ROWS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        drain_cnt_d = drain_cnt_q + RW'(1);
                    end
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            feed_cnt_q  <= '0;
            flush_cnt_q <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            feed_cnt_q  <= feed_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

`ifdef GEMM_TILE_CTRL_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;
    logic        stall_cycle;

    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_stalls_d = perf_stalls_q;
        stall_cycle   = ((state_q == ST_FEED)  && !operand_valid) ||
                        ((state_q == ST_DRAIN) && !drain_ready);
        if (accept) begin
            perf_cycles_d = '0;
            perf_stalls_d = '0;
        end else begin
            // Counters hold once the tile returns to IDLE and saturate
            // rather than wrap.
            if (busy && (perf_cycles_q != '1)) begin
                perf_cycles_d = perf_cycles_q + 32'd1;
            end
            if (stall_cycle && (perf_stalls_q != '1)) begin
                perf_stalls_d = perf_stalls_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_gemm_tile_ctrl.sv
module tb_gemm_tile_ctrl;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int K_W  = 16;
    localparam int RW   = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [K_W-1:0]  k_len;
    logic            operand_valid;
    logic            drain_ready;
    logic            busy;
    logic            done;
    logic            clear_acc;
    logic            en;
    logic [K_W-1:0]  feed_k;
    logic            feed_zero;
    logic            drain_valid;
    logic [RW-1:0]   drain_row;
`ifdef GEMM_TILE_CTRL_PERF_EN
    logic [31:0]     perf_cycles;
    logic [31:0]     perf_stalls;
`endif

    gemm_tile_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_W(K_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .k_len         (k_len),
        .operand_valid (operand_valid),
        .drain_ready   (drain_ready),
        .busy          (busy),
        .done          (done),
        .clear_acc     (clear_acc),
        .en            (en),
        .feed_k        (feed_k),
        .feed_zero     (feed_zero),
        .drain_valid   (drain_valid),
`ifdef GEMM_TILE_CTRL_PERF_EN
        .perf_cycles   (perf_cycles),
        .perf_stalls   (perf_stalls),
`endif
        .drain_row     (drain_row)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int mon_e;

    // Scoreboard queues: expected feed indices, drained rows and the cycle
    // number at which done must appear.
    int feed_q[$];
    int drain_q[$];
    int done_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops expectations whenever the DUT produces a beat.
    always @(negedge clk) begin
        #2;
        if (en && !feed_zero) begin
            checks++;
            if (feed_q.size() == 0) begin
                errors++;
                $display("FAIL feed_beat: unexpected feed_k=%0d at cycle %0d", feed_k, cyc);
            end else begin
                mon_e = feed_q.pop_front();
                if (feed_k !== K_W'(mon_e)) begin
                    errors++;
                    $display("FAIL feed_k: got %0d expected %0d", feed_k, mon_e);
                end
            end
        end
        if (drain_valid && drain_ready) begin
            checks++;
            if (drain_q.size() == 0) begin
                errors++;
                $display("FAIL drain_beat: unexpected drain_row=%0d at cycle %0d", drain_row, cyc);
            end else begin
                mon_e = drain_q.pop_front();
                if (drain_row !== RW'(mon_e)) begin
                    errors++;
                    $display("FAIL drain_row: got %0d expected %0d", drain_row, mon_e);
                end
            end
        end
        if (done) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL done_pulse: unexpected done at cycle %0d", cyc);
            end else begin
                mon_e = done_q.pop_front();
                if (cyc !== mon_e) begin
                    errors++;
                    $display("FAIL done_time: got cycle %0d expected %0d", cyc, mon_e);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; k_len = '0; operand_valid = 1'b0; drain_ready = 1'b0;
        #1;
        checks++;
        if ({busy, done, clear_acc, en, feed_zero, drain_valid} !== 6'b0 ||
            feed_k !== '0 || drain_row !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ctrl=%b feed_k=%0d row=%0d expected all 0",
                     {busy, done, clear_acc, en, feed_zero, drain_valid}, feed_k, drain_row);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_basic();
        int a, n_clr, n_en, n_fz;
        bit seen;
        n_clr = 0; n_en = 0; n_fz = 0; seen = 0;
        @(negedge clk);
        start = 1'b1; k_len = 16'd8; operand_valid = 1'b1; drain_ready = 1'b1;
        a = cyc;
        for (int i = 0; i < 8; i++) feed_q.push_back(i);
        for (int r = 0; r < ROWS; r++) drain_q.push_back(r);
        done_q.push_back(a + 21);
        for (int off = 1; off <= 40; off++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (clear_acc) n_clr++;
            if (en) n_en++;
            if (feed_zero) n_fz++;
            if (off == 1) begin
                checks++;
                if (clear_acc !== 1'b1 || en !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_clear: clear_acc=%b en=%b busy=%b expected 1 0 1", clear_acc, en, busy);
                end
            end
            if (done) begin seen = 1; break; end
        end
        checks++;
        if (seen !== 1'b1) begin errors++; $display("FAIL basic_done_seen: got 0 expected 1"); end
        checks++;
        if (n_clr !== 1) begin errors++; $display("FAIL basic_clear_count: got %0d expected 1", n_clr); end
        checks++;
        if (n_en !== 15) begin errors++; $display("FAIL basic_en_count: got %0d expected 15", n_en); end
        checks++;
        if (n_fz !== 7) begin errors++; $display("FAIL basic_flush_count: got %0d expected 7", n_fz); end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: busy=%b expected 0", busy); end
`ifdef GEMM_TILE_CTRL_PERF_EN
        checks++;
        if (perf_cycles !== 32'd21) begin errors++; $display("FAIL basic_perf_cycles: got %0d expected 21", perf_cycles); end
        checks++;
        if (perf_stalls !== 32'd0) begin errors++; $display("FAIL basic_perf_stalls: got %0d expected 0", perf_stalls); end
`endif
        checks++;
        if (feed_q.size() != 0 || drain_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL basic_drained: left feed=%0d drain=%0d done=%0d expected 0", feed_q.size(), drain_q.size(), done_q.size());
        end
        feed_q.delete(); drain_q.delete(); done_q.delete();
    endtask

    task automatic test_feed_stall();
        int a;
        @(negedge clk);
        start = 1'b1; k_len = 16'd8; operand_valid = 1'b1; drain_ready = 1'b1;
        a = cyc;
        for (int i = 0; i < 8; i++) feed_q.push_back(i);
        for (int r = 0; r < ROWS; r++) drain_q.push_back(r);
        done_q.push_back(a + 24);
        for (int off = 1; off <= 40; off++) begin
            @(negedge clk);
            start = 1'b0;
            operand_valid = !(off inside {6, 7, 8});
            #1;
            if (off inside {6, 7, 8}) begin
                checks++;
                if (en !== 1'b0 || feed_k !== 16'd4) begin
                    errors++;
                    $display("FAIL stall_hold: off=%0d en=%b feed_k=%0d expected en=0 feed_k=4", off, en, feed_k);
                end
            end
            if (done) break;
        end
        operand_valid = 1'b1;
        @(negedge clk); #1;
`ifdef GEMM_TILE_CTRL_PERF_EN
        checks++;
        if (perf_stalls !== 32'd3) begin errors++; $display("FAIL stall_perf_stalls: got %0d expected 3", perf_stalls); end
        checks++;
        if (perf_cycles !== 32'd24) begin errors++; $display("FAIL stall_perf_cycles: got %0d expected 24", perf_cycles); end
`endif
        checks++;
        if (feed_q.size() != 0 || drain_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL stall_drained: left feed=%0d drain=%0d done=%0d expected 0", feed_q.size(), drain_q.size(), done_q.size());
        end
        feed_q.delete(); drain_q.delete(); done_q.delete();
    endtask

    task automatic test_drain_stall();
        int a;
        @(negedge clk);
        start = 1'b1; k_len = 16'd8; operand_valid = 1'b1; drain_ready = 1'b1;
        a = cyc;
        for (int i = 0; i < 8; i++) feed_q.push_back(i);
        for (int r = 0; r < ROWS; r++) drain_q.push_back(r);
        done_q.push_back(a + 23);
        for (int off = 1; off <= 40; off++) begin
            @(negedge clk);
            start = 1'b0;
            drain_ready = !(off inside {19, 20});
            #1;
            if (off inside {19, 20}) begin
                checks++;
                if (drain_valid !== 1'b1 || drain_row !== 2'd2 || en !== 1'b0) begin
                    errors++;
                    $display("FAIL drain_hold: off=%0d valid=%b row=%0d en=%b expected 1 2 0", off, drain_valid, drain_row, en);
                end
            end
            if (done) break;
        end
        drain_ready = 1'b1;
        @(negedge clk); #1;
`ifdef GEMM_TILE_CTRL_PERF_EN
        checks++;
        if (perf_stalls !== 32'd2) begin errors++; $display("FAIL drain_perf_stalls: got %0d expected 2", perf_stalls); end
`endif
        checks++;
        if (feed_q.size() != 0 || drain_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL drain_drained: left feed=%0d drain=%0d done=%0d expected 0", feed_q.size(), drain_q.size(), done_q.size());
        end
        feed_q.delete(); drain_q.delete(); done_q.delete();
    endtask

    task automatic test_k_zero();
        int a, n_en;
        n_en = 0;
        @(negedge clk);
        start = 1'b1; k_len = 16'd0; operand_valid = 1'b1; drain_ready = 1'b1;
        a = cyc;
        for (int r = 0; r < ROWS; r++) drain_q.push_back(r);
        done_q.push_back(a + 6);
        for (int off = 1; off <= 20; off++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (en) n_en++;
            if (off == 2) begin
                checks++;
                if (drain_valid !== 1'b1 || drain_row !== 2'd0) begin
                    errors++;
                    $display("FAIL kzero_drain_direct: valid=%b row=%0d expected 1 0", drain_valid, drain_row);
                end
            end
            if (done) break;
        end
        checks++;
        if (n_en !== 0) begin errors++; $display("FAIL kzero_en_count: got %0d expected 0", n_en); end
        @(negedge clk); #1;
`ifdef GEMM_TILE_CTRL_PERF_EN
        checks++;
        if (perf_cycles !== 32'd6) begin errors++; $display("FAIL kzero_perf_cycles: got %0d expected 6", perf_cycles); end
`endif
        checks++;
        if (drain_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL kzero_drained: left drain=%0d done=%0d expected 0", drain_q.size(), done_q.size());
        end
        drain_q.delete(); done_q.delete();
    endtask

    task automatic test_ignore_start();
        int a;
        @(negedge clk);
        start = 1'b1; k_len = 16'd3; operand_valid = 1'b1; drain_ready = 1'b1;
        a = cyc;
        for (int i = 0; i < 3; i++) feed_q.push_back(i);
        for (int r = 0; r < ROWS; r++) drain_q.push_back(r);
        done_q.push_back(a + 16);
        for (int off = 1; off <= 18; off++) begin
            @(negedge clk);
            // Re-requests with a different length during FEED and DONE.
            start = (off inside {2, 3, 4, 16});
            k_len = start ? 16'd2 : 16'd3;
            #1;
            if (off inside {17, 18}) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL ignore_start_idle: off=%0d busy=%b expected 0", off, busy);
                end
            end
        end
        checks++;
        if (feed_q.size() != 0 || drain_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL ignore_drained: left feed=%0d drain=%0d done=%0d expected 0", feed_q.size(), drain_q.size(), done_q.size());
        end
        feed_q.delete(); drain_q.delete(); done_q.delete();
    endtask

    task automatic test_reset_mid();
        int a, n_done;
        bit seen;
        n_done = 0; seen = 0;
        @(negedge clk);
        start = 1'b1; k_len = 16'd8; operand_valid = 1'b1; drain_ready = 1'b1;
        for (int i = 0; i < 8; i++) feed_q.push_back(i);
        for (int off = 1; off <= 12; off++) begin
            @(negedge clk);
            start = 1'b0;
            if (off == 12) rst_n = 1'b0;
            #1;
        end
        checks++;
        if ({busy, done, clear_acc, en, feed_zero, drain_valid} !== 6'b0 ||
            feed_k !== '0 || drain_row !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got ctrl=%b feed_k=%0d row=%0d expected all 0",
                     {busy, done, clear_acc, en, feed_zero, drain_valid}, feed_k, drain_row);
        end
        checks++;
        if (feed_q.size() != 0) begin errors++; $display("FAIL midreset_feed: left %0d expected 0", feed_q.size()); end
        feed_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int off = 0; off < 25; off++) begin
            @(negedge clk); #1;
            if (done) n_done++;
        end
        checks++;
        if (n_done !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d done pulses expected 0", n_done); end

        @(negedge clk);
        start = 1'b1; k_len = 16'd2;
        a = cyc;
        for (int i = 0; i < 2; i++) feed_q.push_back(i);
        for (int r = 0; r < ROWS; r++) drain_q.push_back(r);
        done_q.push_back(a + 15);
        for (int off = 1; off <= 30; off++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (done) begin seen = 1; break; end
        end
        checks++;
        if (seen !== 1'b1) begin errors++; $display("FAIL midreset_fresh_done: got 0 expected 1"); end
        @(negedge clk); #1;
        checks++;
        if (feed_q.size() != 0 || drain_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_drained: left feed=%0d drain=%0d done=%0d expected 0", feed_q.size(), drain_q.size(), done_q.size());
        end
        feed_q.delete(); drain_q.delete(); done_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_feed_stall();
        test_drain_stall();
        test_k_zero();
        test_ignore_start();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gemm_tile_ctrl.md
GEMM_TILE_CTRL -- requirements
Module: gemm_tile_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 4, systolic array row count (drain beats).
REQ-002 SHALL have parameter COLS, default 4, systolic array column count.
REQ-003 SHALL have parameter K_W, default 16, width of reduction-length count.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  tile request, sampled only in IDLE.
REQ-007 SHALL have port k_len  input  K_W  reduction length K, latched on start accept.
REQ-008 SHALL have port operand_valid  input  1  upstream skew buffers hold operands for feed_k.
REQ-009 SHALL have port drain_ready  input  1  result sink accepts drain_row this cycle.
REQ-010 SHALL have port busy  output  1  high from the cycle after start accept through DONE.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port clear_acc  output  1  accumulator clear to all PEs.
REQ-013 SHALL have port en  output  1  array-wide enable to all PEs.
REQ-014 SHALL have port feed_k  output  K_W  operand index requested.
REQ-015 SHALL have port feed_zero  output  1  skew buffers inject zeros.
REQ-016 SHALL have ports drain_valid  output  1  and drain_row  output  $clog2(ROWS)  result row offered.

Function
REQ-017 SHALL implement FSM IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE; all outputs registered or decoded from state/counters only.
REQ-018 IDLE: start=1 latches k_len, next state CLEAR; start in any other state SHALL be ignored.
REQ-019 CLEAR: one cycle, clear_acc=1, en=0; next FEED if latched K>0, else DRAIN.
REQ-020 FEED: en=operand_valid, feed_k=current index from 0; index increments only when operand_valid=1.
REQ-021 FEED: operand_valid=0 SHALL hold en=0 (whole array frozen) and feed_k unchanged.
REQ-022 FEED exits to FLUSH on the cycle operand_valid=1 with feed_k=K-1.
REQ-023 FLUSH: exactly ROWS+COLS-1 cycles, en=1, feed_zero=1, independent of operand_valid.
REQ-024 DRAIN: drain_valid=1, drain_row from 0; row advances on drain_ready=1; en=0, clear_acc=0.
REQ-025 DRAIN exits to DONE when drain_ready=1 with drain_row=ROWS-1; drain_ready=0 SHALL hold indefinitely.
REQ-026 DONE: one cycle, done=1, busy=1; next IDLE; start in DONE ignored.
REQ-027 Unstalled latency from start-accept edge to done SHALL be K+ROWS+COLS+ROWS+1 cycles (CLEAR 1, FEED K, FLUSH ROWS+COLS-1, DRAIN ROWS, DONE 1).
REQ-028 k_len wider values SHALL be counted modulo nothing: feed counter K_W bits, max K=2^K_W-1, no wrap.

Reset
REQ-029 rst_n=0 SHALL force IDLE asynchronously; busy, done, clear_acc, en, feed_zero, drain_valid =0; feed_k, drain_row =0.
REQ-030 Reset mid-tile SHALL abandon the tile; no done pulse issued.

Configuration
REQ-031 With GEMM_TILE_CTRL_PERF_EN defined, SHALL add outputs perf_cycles (32) and perf_stalls (32), cleared on start accept; perf_cycles counts every busy cycle, perf_stalls counts FEED cycles with operand_valid=0 plus DRAIN cycles with drain_ready=0; both hold after DONE, saturate at all-ones.
REQ-032 Without GEMM_TILE_CTRL_PERF_EN, those ports and counters SHALL not exist.

Structure
REQ-033 State enum typedef and FLUSH-length helper function SHALL live in shared package gemm_pkg.
REQ-034 SHALL be a single module, no sub-modules; datapath (PE array, skew buffers) external.

Verification
REQ-035 ROWS=COLS=4, k_len=8, operand_valid=1, drain_ready=1 -> clear_acc 1 cycle, en high 8+7 cycles, feed_k 0..7, drain_row 0..3, done 21 cycles after accept; perf_cycles=21.
REQ-036 k_len=8, operand_valid low 3 cycles at feed_k=4 -> en=0 and feed_k=4 held those cycles, done at 24; perf_stalls=3.
REQ-037 k_len=0 -> CLEAR then DRAIN directly, no en pulse, done 6 cycles after accept.
REQ-038 drain_ready low 2 cycles at drain_row=2 -> drain_row held at 2, done delayed 2 cycles.
REQ-039 start pulsed during FEED and during DONE -> ignored; exactly one done per accepted start.
REQ-040 rst_n asserted during FLUSH -> all outputs 0 immediately, no done; fresh start after release completes normally.
